fp_cvt_f2i_seq: RTL and testbench
=================================

FP_CVT_F2I_SEQ -- requirements
Module: fp_cvt_f2i_seq

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning bit positions shifted per SHIFT cycle (legal: 1, 2, 4, 8).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port data1  input  32  f32 operand.
REQ-006 SHALL have port rm  input  3  rounding mode: 0 rne, 1 rtz, 2 rdn, 3 rup, 4 rmm; 5-7 treated as rne.
REQ-007 SHALL have port fcvt_op  input  2  0 = f32_to_i32, 1 = f32_to_ui32; 2-3 treated as 0.
REQ-008 SHALL have port result  output  32  converted integer, registered.
REQ-009 SHALL have port flags  output  5  {NV,DZ,OF,UF,NX}, registered; DZ, OF, UF always 0.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse, registered.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, ROUND.
REQ-012 IDLE with enable=1 SHALL capture data1, rm, fcvt_op, then unpack: sign, exponent e, 24-bit significand (hidden bit 0 and e treated as 1 when e=0).
REQ-013 Special operands (NaN, +/-inf, e>=159, or any zero) SHALL go IDLE->ROUND with shift count N=0.
REQ-014 Otherwise e in 151..158 SHALL set left shift N=e-150; e<=150 SHALL set right shift N=min(150-e,33); IDLE->SHIFT if N>0, else ROUND.
REQ-015 The working register SHALL hold 32 integer bits plus guard, round and sticky bits; right shifts SHALL OR all shifted-out bits into sticky.
REQ-016 SHIFT SHALL shift by min(STEP,N) per cycle and decrement N by the same amount; at N=0, go to ROUND.
REQ-017 ROUND SHALL apply rm to the magnitude (rne ties-to-even, rmm ties-away, rdn/rup by sign), negate if sign=1, check range, load result/flags, set ready=1, go to IDLE.
REQ-018 Latency SHALL be 2+ceil(N/STEP) rising edges from the enable-sampling edge to ready=1; specials SHALL take exactly 2.
REQ-019 ready SHALL be high for exactly one cycle; result/flags SHALL hold until the next completion.
REQ-020 enable while in SHIFT or ROUND SHALL be ignored, with no queueing; enable may be re-accepted in the same cycle ready is high (state IDLE).
REQ-021 NaN SHALL produce i32 0x7FFFFFFF and ui32 0xFFFFFFFF, flags 0x10.
REQ-022 Rounded value above range (incl. +inf, rounding carry) SHALL produce i32 0x7FFFFFFF and ui32 0xFFFFFFFF, flags 0x10.
REQ-023 Rounded value below range SHALL produce i32 0x80000000 and ui32 0x00000000, flags 0x10; exactly -2^31 for i32 SHALL be valid.
REQ-024 ui32 negative input rounding to 0 SHALL produce 0x00000000 with NX only, not NV.
REQ-025 Valid inexact result SHALL set flags 0x01; exact result SHALL set 0x00; NV and NX SHALL never both be set.
REQ-026 Zero of either sign SHALL produce 0x00000000, flags 0x00.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, N=0, result=0, flags=0, ready=0, independent of clock.
REQ-028 Reset mid-SHIFT or mid-ROUND SHALL abort the operation, producing no ready pulse; first request after release SHALL complete normally.

Verification
REQ-029 0x3FC00000 (1.5), op 0, rne, STEP=1 -> result 0x00000002, flags 0x01, ready on edge 25.
REQ-030 0xCF000000 (-2^31), op 0, rtz -> 0x80000000, flags 0x00, latency 10; same with op 1 -> 0x00000000, flags 0x10.
REQ-031 0x7FC00000, op 1 -> 0xFFFFFFFF, flags 0x10, latency 2; 0x4F800000 (2^32), op 1 -> 0xFFFFFFFF, flags 0x10, latency 2.
REQ-032 0xBF000000 (-0.5), op 1: rdn -> 0x00000000 flags 0x10; rtz -> 0x00000000 flags 0x01; rne -> 0x00000000 flags 0x01.
REQ-033 enable re-pulsed every cycle during a 0x40200000 (2.5) rne conversion -> exactly one ready, result 0x00000002, flags 0x01; back-to-back on the ready cycle accepted.
REQ-034 reset low during SHIFT -> ready, result, flags go 0 asynchronously, no ready pulse; then 0x41200000 (10.0) op 0 -> 0x0000000A, flags 0x00.

Source files
------------

// File: rtl/fp_cvt_f2i_seq.sv
// Sequential f32 -> i32/ui32 converter. The significand is aligned by a
// STEP-bit-per-cycle shifter, then rounded, range-checked and registered.
module fp_cvt_f2i_seq #(
  parameter int unsigned STEP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data1,
  input  logic [2:0]  rm,
  input  logic [1:0]  fcvt_op,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [34:0] wr_q, wr_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        nan_q, nan_d;
  logic        huge_q, huge_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;
  logic        ready_q, ready_d;

  logic [7:0]  exp_raw, exp_eff, n8, diff8;
  logic [23:0] sig;
  logic        is_nan, is_special;
  logic [5:0]  step_amt;
  logic [34:0] shifted, sticky_mask;
  logic [31:0] mag;
  logic [32:0] mag_r;
  logic        g_bit, rs_bit, inexact, inc, nv;
  logic [31:0] res;

  always_comb begin
    exp_raw    = data1[30:23];
    exp_eff    = (exp_raw == 8'd0) ? 8'd1 : exp_raw;
    sig        = {exp_raw != 8'd0, data1[22:0]};
    is_nan     = (exp_raw == 8'hFF) && (data1[22:0] != 23'd0);
    is_special = (exp_raw >= 8'd159) || (data1[30:0] == 31'd0);
    diff8      = 8'd150 - exp_eff;
    if (exp_eff > 8'd150) n8 = exp_eff - 8'd150;
    else                  n8 = (diff8 > 8'd33) ? 8'd33 : diff8;

    step_amt    = (n_q < STEP_W) ? n_q : STEP_W;
    shifted     = wr_q >> step_amt;
    // Every bit at or below the shift amount collapses into the sticky bit.
    sticky_mask = ((35'd1 << step_amt) << 1) - 35'd1;

    mag     = wr_q[34:3];
    g_bit   = wr_q[2];
    rs_bit  = |wr_q[1:0];
    inexact = g_bit | rs_bit;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inexact;
      3'd3:    inc = ~sign_q & inexact;
      3'd4:    inc = g_bit;
      default: inc = g_bit & (rs_bit | mag[0]);
    endcase
    mag_r = {1'b0, mag} + {32'd0, inc};

    nv  = 1'b0;
    res = 32'd0;
    if (nan_q) begin
      nv  = 1'b1;
      res = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (huge_q) begin
      nv  = 1'b1;
      if (uns_q) res = sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
      else       res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (uns_q) begin
      if (sign_q) begin
        nv  = (mag_r != 33'd0);
        res = 32'd0;
      end else if (mag_r[32]) begin
        nv  = 1'b1;
        res = 32'hFFFF_FFFF;
      end else begin
        res = mag_r[31:0];
      end
    end else begin
      if (sign_q) begin
        if (mag_r > 33'h0_8000_0000) begin
          nv  = 1'b1;
          res = 32'h8000_0000;
        end else begin
          res = ~mag_r[31:0] + 32'd1;
        end
      end else if (mag_r > 33'h0_7FFF_FFFF) begin
        nv  = 1'b1;
        res = 32'h7FFF_FFFF;
      end else begin
        res = mag_r[31:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wr_d     = wr_q;
    left_d   = left_q;
    sign_d   = sign_q;
    nan_d    = nan_q;
    huge_d   = huge_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    result_d = result_q;
    flags_d  = flags_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          sign_d = data1[31];
          rm_d   = rm;
          uns_d  = (fcvt_op == 2'd1);
          nan_d  = is_nan;
          huge_d = (exp_raw >= 8'd159) && !is_nan;
          left_d = (exp_eff > 8'd150);
          wr_d   = {8'd0, sig, 3'd0};
          if (is_special) begin
            n_d     = 6'd0;
            wr_d    = 35'd0;
            state_d = ROUND;
          end else begin
            n_d     = n8[5:0];
            state_d = (n8 == 8'd0) ? ROUND : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_q) wr_d = wr_q << step_amt;
        else        wr_d = {shifted[34:1], |(wr_q & sticky_mask)};
        n_d = n_q - step_amt;
        if (n_q == step_amt) state_d = ROUND;
      end
      ROUND: begin
        result_d = res;
        flags_d  = nv ? 5'b10000 : {4'b0000, inexact};
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      n_q      <= 6'd0;
      wr_q     <= 35'd0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      huge_q   <= 1'b0;
      uns_q    <= 1'b0;
      rm_q     <= 3'd0;
      result_q <= 32'd0;
      flags_q  <= 5'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wr_q     <= wr_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      nan_q    <= nan_d;
      huge_q   <= huge_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_fp_cvt_f2i_seq.sv
// Directed bench for fp_cvt_f2i_seq (STEP=1): values, flags, latency,
// enable blocking, back-to-back acceptance and asynchronous reset abort.
module tb_fp_cvt_f2i_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data1 = 32'd0;
  logic [2:0]  rm = 3'd0;
  logic [1:0]  fcvt_op = 2'd0;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        ready;

  int errors = 0;
  int checks = 0;

  fp_cvt_f2i_seq dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .data1   (data1),
    .rm      (rm),
    .fcvt_op (fcvt_op),
    .result  (result),
    .flags   (flags),
    .ready   (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge 1 is the edge that samples enable; latency is the edge index after
  // which ready is first seen high.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (ready !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic conv(input string tag, input logic [31:0] d, input logic [2:0] m,
                      input logic [1:0] op, input logic [31:0] er, input logic [4:0] ef,
                      input int el);
    int lat;
    @(negedge clock);
    data1 = d; rm = m; fcvt_op = op; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    wait_ready(lat);
    check({tag, "/ready"},   32'(ready), 32'd1);
    check({tag, "/latency"}, 32'(lat),   32'(el));
    check({tag, "/result"},  result,     er);
    check({tag, "/flags"},   32'(flags), 32'(ef));
    @(posedge clock); #1;
    check({tag, "/pulse"},   32'(ready), 32'd0);
    check({tag, "/hold"},    result,     er);
  endtask

  initial begin
    int lat;
    int rdy_cnt;

    #12;
    check("rst/result", result, 32'd0);
    check("rst/flags",  32'(flags), 32'd0);
    check("rst/ready",  32'(ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    conv("one_p5_rne",   32'h3FC00000, 3'd0, 2'd0, 32'h00000002, 5'h01, 25);
    conv("m2p31_rtz",    32'hCF000000, 3'd1, 2'd0, 32'h80000000, 5'h00, 10);
    conv("m2p31_u_rtz",  32'hCF000000, 3'd1, 2'd1, 32'h00000000, 5'h10, 10);
    conv("nan_u",        32'h7FC00000, 3'd0, 2'd1, 32'hFFFFFFFF, 5'h10, 2);
    conv("nan_i",        32'h7FC00000, 3'd0, 2'd0, 32'h7FFFFFFF, 5'h10, 2);
    conv("2p32_u",       32'h4F800000, 3'd0, 2'd1, 32'hFFFFFFFF, 5'h10, 2);
    conv("mhalf_u_rdn",  32'hBF000000, 3'd2, 2'd1, 32'h00000000, 5'h10, 26);
    conv("mhalf_u_rtz",  32'hBF000000, 3'd1, 2'd1, 32'h00000000, 5'h01, 26);
    conv("mhalf_u_rne",  32'hBF000000, 3'd0, 2'd1, 32'h00000000, 5'h01, 26);
    conv("2p31_i",       32'h4F000000, 3'd0, 2'd0, 32'h7FFFFFFF, 5'h10, 10);
    conv("2p31_u",       32'h4F000000, 3'd0, 2'd1, 32'h80000000, 5'h00, 10);
    conv("ninf_i",       32'hFF800000, 3'd0, 2'd0, 32'h80000000, 5'h10, 2);
    conv("pinf_u",       32'h7F800000, 3'd0, 2'd1, 32'hFFFFFFFF, 5'h10, 2);
    conv("nzero_i",      32'h80000000, 3'd0, 2'd0, 32'h00000000, 5'h00, 2);
    conv("m1p5_rne",     32'hBFC00000, 3'd0, 2'd0, 32'hFFFFFFFE, 5'h01, 25);
    conv("m1p5_rup",     32'hBFC00000, 3'd3, 2'd0, 32'hFFFFFFFF, 5'h01, 25);
    conv("2p5_rmm",      32'h40200000, 3'd4, 2'd0, 32'h00000003, 5'h01, 24);
    conv("2p5_rm5",      32'h40200000, 3'd5, 2'd0, 32'h00000002, 5'h01, 24);
    conv("3p0_op3",      32'h40400000, 3'd0, 2'd3, 32'h00000003, 5'h00, 24);
    conv("maxu_exact",   32'h4F7FFFFF, 3'd0, 2'd1, 32'hFFFFFF00, 5'h00, 10);
    conv("subn_rup",     32'h00000001, 3'd3, 2'd0, 32'h00000001, 5'h01, 35);
    conv("subn_rtz",     32'h00000001, 3'd1, 2'd0, 32'h00000000, 5'h01, 35);

    // Enable held high through a conversion with different data on the bus:
    // only the first request counts, the one on the ready cycle is accepted.
    @(negedge clock);
    data1 = 32'h40200000; rm = 3'd0; fcvt_op = 2'd0; enable = 1'b1;
    @(posedge clock); #1;
    data1 = 32'h41200000;
    wait_ready(lat);
    check("hold_en/ready",   32'(ready), 32'd1);
    check("hold_en/latency", 32'(lat),   32'd24);
    check("hold_en/result",  result,     32'h00000002);
    check("hold_en/flags",   32'(flags), 32'h01);
    @(posedge clock); #1;
    enable = 1'b0;
    check("b2b/pulse", 32'(ready), 32'd0);
    wait_ready(lat);
    check("b2b/ready",   32'(ready), 32'd1);
    check("b2b/latency", 32'(lat),   32'd22);
    check("b2b/result",  result,     32'h0000000A);
    check("b2b/flags",   32'(flags), 32'h00);

    // Reset mid-SHIFT: outputs clear without a clock edge, no late ready.
    @(negedge clock);
    data1 = 32'h3FC00000; rm = 3'd0; fcvt_op = 2'd0; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst/result", result, 32'd0);
    check("arst/flags",  32'(flags), 32'd0);
    check("arst/ready",  32'(ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (ready === 1'b1) rdy_cnt++;
    end
    check("arst/no_ready", 32'(rdy_cnt), 32'd0);
    conv("post_rst_10", 32'h41200000, 3'd0, 2'd0, 32'h0000000A, 5'h00, 22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
